// File: rtl/dma_sched_pkg.sv
// Shared FSM state, default parameters and output beat layout for dma_cmd_rr_scheduler.
package dma_sched_pkg;

  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_CMD_WIDTH       = 160;
  localparam int DEF_MAX_OUTSTANDING = 8;
  localparam int DEF_ID_W            = $clog2(DEF_NUM_REQ);
  localparam int STAT_W              = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

  // Beat layout on m_axis_cmd at the default parameters: {req_id, cmd}.
  typedef struct packed {
    logic [DEF_ID_W-1:0]      req_id;
    logic [DEF_CMD_WIDTH-1:0] cmd;
  } out_beat_t;

endpackage

// File: rtl/dma_cmd_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request after last_grant, searched in a doubled request vector.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  int unsigned          base;
  int unsigned          idx;

  always_comb begin
    req_dbl = {req, req};
    base    = {{(32-ID_W){1'b0}}, last_grant} + 32'd1;
    if (base >= 32'(NUM_REQ)) begin
      base = 32'd0;
    end
    // Bit k of req_rot is requester (base + k) mod NUM_REQ.
    req_rot = NUM_REQ'(req_dbl >> base);
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && req_rot[k]) begin
        gnt_vld = 1'b1;
        idx     = base + 32'(k);
        if (idx >= 32'(NUM_REQ)) begin
          idx = idx - 32'(NUM_REQ);
        end
        gnt_id = idx[ID_W-1:0];
      end
    end
    gnt[gnt_id] = gnt_vld;
  end

endmodule

// File: rtl/dma_cmd_rr_scheduler.sv
// Round-robin, per-requester credit-limited sharing of one DMA command port.
// Define DMA_SCHED_STATS_EN to add per-requester issue counters and a stall counter.
module dma_cmd_rr_scheduler
  import dma_sched_pkg::*;
#(
  parameter  int NUM_REQ         = DEF_NUM_REQ,
  parameter  int CMD_WIDTH       = DEF_CMD_WIDTH,
  parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  localparam int ID_W            = $clog2(NUM_REQ)
) (
  input  logic                              user_clk,
  input  logic                              user_aresetn,
  input  logic [NUM_REQ-1:0]                s_axis_cmd_valid,
  output logic [NUM_REQ-1:0]                s_axis_cmd_ready,
  input  logic [NUM_REQ-1:0][CMD_WIDTH-1:0] s_axis_cmd_data,
  output logic                              m_axis_cmd_valid,
  input  logic                              m_axis_cmd_ready,
  output logic [ID_W+CMD_WIDTH-1:0]         m_axis_cmd_data,
  input  logic                              s_axis_done_valid,
  output logic                              s_axis_done_ready,
  input  logic [ID_W-1:0]                   s_axis_done_data,
  output logic                              credit_err,
  output logic                              busy
`ifdef DMA_SCHED_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_W-1:0]    stat_issue_cnt,
  output logic [STAT_W-1:0]                 stat_stall_cnt
`endif
);

  localparam int                CRED_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUTSTANDING);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);
  localparam int                DEC_N    = 1 << ID_W;

  sched_state_e                   state_q, state_d;
  logic [NUM_REQ-1:0][CRED_W-1:0] credit_q, credit_d;
  logic [ID_W-1:0]                last_grant_q, last_grant_d;
  logic [ID_W+CMD_WIDTH-1:0]      out_dat_q, out_dat_d;
  logic                           credit_err_q, credit_err_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    arb_id;
  logic               arb_vld;
  logic               grant_vld;
  logic [DEC_N-1:0]   done_dec;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = s_axis_cmd_valid[i] && (credit_q[i] != '0);
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req        (eligible),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .gnt_id     (arb_id),
    .gnt_vld    (arb_vld)
  );

  // A grant needs the output register free: idle, or draining this cycle.
  assign grant_vld        = user_aresetn && arb_vld && ((state_q == IDLE) || m_axis_cmd_ready);
  assign grant            = grant_vld ? arb_gnt : '0;
  assign s_axis_cmd_ready = grant;

  always_comb begin
    done_dec                   = '0;
    done_dec[s_axis_done_data] = s_axis_done_valid;
  end

  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q || (|(done_dec >> NUM_REQ));
    for (int i = 0; i < NUM_REQ; i++) begin
      case ({grant[i], done_dec[i]})
        2'b10:   credit_d[i] = credit_q[i] - CRED_ONE;
        2'b01: begin
          if (credit_q[i] == CRED_MAX) begin
            credit_err_d = 1'b1;
          end else begin
            credit_d[i] = credit_q[i] + CRED_ONE;
          end
        end
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_dat_d    = out_dat_q;
    if (grant_vld) begin
      state_d      = ISSUE;
      last_grant_d = arb_id;
      out_dat_d    = {arb_id, s_axis_cmd_data[arb_id]};
    end else if ((state_q == ISSUE) && m_axis_cmd_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      out_dat_q    <= '0;
      credit_err_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= CRED_MAX;
      end
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_dat_q    <= out_dat_d;
      credit_err_q <= credit_err_d;
      credit_q     <= credit_d;
    end
  end

  assign m_axis_cmd_valid  = (state_q == ISSUE);
  assign m_axis_cmd_data   = out_dat_q;
  assign s_axis_done_ready = 1'b1;
  assign credit_err        = credit_err_q;

  always_comb begin
    busy = (state_q == ISSUE);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (credit_q[i] != CRED_MAX) begin
        busy = 1'b1;
      end
    end
  end

`ifdef DMA_SCHED_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [STAT_W-1:0]              stall_cnt_q, stall_cnt_d;
  logic [ID_W-1:0]                out_id;

  assign out_id = out_dat_q[ID_W+CMD_WIDTH-1 -: ID_W];

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (m_axis_cmd_valid && m_axis_cmd_ready) begin
      issue_cnt_d[out_id] = issue_cnt_q[out_id] + STAT_W'(1);
    end
    if (m_axis_cmd_valid && !m_axis_cmd_ready) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_aresetn) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_issue_cnt = issue_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dma_cmd_rr_scheduler.sv
// Scoreboard bench for dma_cmd_rr_scheduler: per-requester expected-command queues plus grant/beat timing logs.
module tb_dma_cmd_rr_scheduler;
  import dma_sched_pkg::*;

  localparam int NR   = DEF_NUM_REQ;
  localparam int CW   = DEF_CMD_WIDTH;
  localparam int IW   = DEF_ID_W;
  localparam int MAXO = DEF_MAX_OUTSTANDING;

  logic                   user_clk = 1'b0;
  logic                   user_aresetn = 1'b0;
  logic [NR-1:0]          s_valid;
  logic [NR-1:0]          s_ready;
  logic [NR-1:0][CW-1:0]  s_data;
  logic                   m_valid;
  logic                   m_ready;
  out_beat_t              m_data;
  logic                   done_valid;
  logic                   done_ready;
  logic [IW-1:0]          done_data;
  logic                   credit_err;
  logic                   busy;
`ifdef DMA_SCHED_STATS_EN
  logic [NR-1:0][31:0]    stat_issue_cnt;
  logic [31:0]            stat_stall_cnt;
`endif

  dma_cmd_rr_scheduler #(
    .NUM_REQ(NR), .CMD_WIDTH(CW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .user_clk          (user_clk),
    .user_aresetn      (user_aresetn),
    .s_axis_cmd_valid  (s_valid),
    .s_axis_cmd_ready  (s_ready),
    .s_axis_cmd_data   (s_data),
    .m_axis_cmd_valid  (m_valid),
    .m_axis_cmd_ready  (m_ready),
    .m_axis_cmd_data   (m_data),
    .s_axis_done_valid (done_valid),
    .s_axis_done_ready (done_ready),
    .s_axis_done_data  (done_data),
    .credit_err        (credit_err),
    .busy              (busy)
`ifdef DMA_SCHED_STATS_EN
    ,
    .stat_issue_cnt    (stat_issue_cnt),
    .stat_stall_cnt    (stat_stall_cnt)
`endif
  );

  always #5 user_clk = ~user_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int seq = 0;
  int done_cyc = 0;
  logic [CW-1:0]    cmd_q [NR][$];
  logic [CW-1:0]    exp_q [NR][$];
  int               g_id[$], g_cyc[$], b_id[$], b_cyc[$];
  logic             smp_m_valid;
  logic [NR-1:0]    smp_s_ready;
  logic [IW+CW-1:0] smp_m_data;
  logic [IW+CW-1:0] exp_beat;

  task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      s_valid[i] = cmd_q[i].size() > 0;
      s_data[i]  = s_valid[i] ? cmd_q[i][0] : '0;
    end
  endtask

  task automatic push_cmd(input int i);
    logic [CW-1:0] c;
    c = {$urandom(), $urandom(), $urandom(), $urandom(), 8'(i), 24'(seq)};
    seq++;
    cmd_q[i].push_back(c);
    exp_q[i].push_back(c);
    drive();
  endtask

  task automatic send_done(input int id);
    done_valid = 1'b1;
    done_data  = IW'(id);
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete(); b_id.delete(); b_cyc.delete();
  endtask

  // Sample on the falling edge, commit handshakes after the rising edge.
  task automatic step();
    logic [NR-1:0] hs;
    @(negedge user_clk);
    cyc++;
    smp_s_ready = s_ready;
    smp_m_valid = m_valid;
    smp_m_data  = m_data;
    hs = s_ready & s_valid;
    check("s_ready_onehot", $countones(s_ready) <= 1, 1);
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        g_id.push_back(i);
        g_cyc.push_back(cyc);
      end
    end
    if (done_valid) done_cyc = cyc;
    if (m_valid && m_ready) begin
      b_id.push_back(int'(m_data.req_id));
      b_cyc.push_back(cyc);
      check("sb_has_entry", exp_q[m_data.req_id].size() > 0, 1);
      if (exp_q[m_data.req_id].size() > 0) begin
        check("beat_cmd", m_data.cmd, exp_q[m_data.req_id].pop_front());
      end
    end
    @(posedge user_clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) void'(cmd_q[i].pop_front());
    end
    done_valid = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    user_aresetn = 1'b0;
    step();
    step();
    user_aresetn = 1'b1;
    clear_logs();
  endtask

  int exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int total;

  initial begin
    s_valid = '0; s_data = '0; m_ready = 1'b0;
    done_valid = 1'b0; done_data = '0;
    step();
    step();
    check("rst_m_valid", smp_m_valid, 0);
    check("rst_m_data", smp_m_data, 0);
    check("rst_s_ready", smp_s_ready, 0);
    check("rst_credit_err", credit_err, 0);
    check("rst_busy", busy, 0);
    for (int i = 0; i < NR; i++) check("rst_credit", dut.credit_q[i], MAXO);
    user_aresetn = 1'b1;
    clear_logs();

    // Single requester, three back-to-back commands.
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_cmd(0);
    for (int k = 0; k < 8; k++) step();
    check("t1_ngrant", g_id.size(), 3);
    check("t1_nbeat", b_id.size(), 3);
    if (g_id.size() == 3 && b_id.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check("t1_gid", g_id[k], 0);
        check("t1_gcyc", g_cyc[k], g_cyc[0] + k);
        check("t1_lat", b_cyc[k], g_cyc[k] + 1);
      end
    end
    check("t1_credit_issued", dut.credit_q[0], MAXO - 3);
    check("t1_busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      send_done(0);
      step();
    end
    step();
    check("t1_credit_back", dut.credit_q[0], MAXO);
    check("t1_busy_idle", busy, 0);

    // All requesters continuously valid: strict rotation.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) push_cmd(i);
    for (int k = 0; k < 12; k++) step();
    check("t2_ngrant", g_id.size(), 8);
    if (g_id.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check("t2_order", g_id[k], exp_ord[k]);
        check("t2_b2b", g_cyc[k], g_cyc[0] + k);
      end
    end

    // Credit exhaustion on requester 1.
    do_reset();
    for (int k = 0; k < 9; k++) push_cmd(1);
    for (int k = 0; k < 12; k++) step();
    check("t3_ngrant", g_id.size(), 8);
    check("t3_held", cmd_q[1].size(), 1);
    check("t3_ready_low", smp_s_ready[1], 0);
    check("t3_credit_zero", dut.credit_q[1], 0);
    clear_logs();
    push_cmd(0);
    push_cmd(2);
    for (int k = 0; k < 4; k++) step();
    check("t3_others_ngrant", g_id.size(), 2);
    if (g_id.size() == 2) begin
      check("t3_other0", g_id[0], 2);
      check("t3_other1", g_id[1], 0);
    end
    check("t3_still_held", cmd_q[1].size(), 1);
    clear_logs();
    send_done(1);
    for (int k = 0; k < 5; k++) step();
    check("t3_regrant_n", g_id.size(), 1);
    if (g_id.size() == 1 && b_id.size() == 1) begin
      check("t3_regrant_id", g_id[0], 1);
      check("t3_regrant_cyc", g_cyc[0], done_cyc + 1);
      check("t3_rebeat_id", b_id[0], 1);
      check("t3_rebeat_cyc", b_cyc[0], done_cyc + 2);
    end

    // Output backpressure for 5 cycles.
    do_reset();
    m_ready = 1'b0;
    push_cmd(2);
    step();
    check("t4_grant", g_id.size(), 1);
    exp_beat = {IW'(2), exp_q[2][0]};
    push_cmd(3);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_valid", smp_m_valid, 1);
      check("t4_data", smp_m_data, exp_beat);
      check("t4_no_s_ready", smp_s_ready, 0);
    end
`ifdef DMA_SCHED_STATS_EN
    check("t4_stall_cnt", stat_stall_cnt, 5);
`endif
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("t4_ngrant", g_id.size(), 2);
    if (g_id.size() == 2) check("t4_next", g_id[1], 3);
`ifdef DMA_SCHED_STATS_EN
    check("t4_issue2", stat_issue_cnt[2], 1);
    check("t4_issue3", stat_issue_cnt[3], 1);
`endif

    // Completion on a full-credit requester.
    do_reset();
    check("t5_err_clear", credit_err, 0);
    send_done(3);
    step();
    check("t5_err_set", credit_err, 1);
    check("t5_credit_kept", dut.credit_q[3], MAXO);
    for (int k = 0; k < 3; k++) step();
    check("t5_err_sticky", credit_err, 1);

    // Reset while a command is in flight.
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_cmd(2);
    for (int k = 0; k < 3; k++) step();
    check("t6_credit_used", dut.credit_q[2], MAXO - 1);
    check("t6_in_flight", smp_m_valid, 1);
    user_aresetn = 1'b0;
    push_cmd(0);
    step();
    check("t6_valid_drop", m_valid, 0);
    check("t6_err_cleared", credit_err, 0);
    for (int i = 0; i < NR; i++) check("t6_credit_rst", dut.credit_q[i], MAXO);
    void'(exp_q[2].pop_front());
    m_ready = 1'b1;
    step();
    check("t6_rst_s_ready", smp_s_ready, 0);
    check("t6_rst_m_valid", smp_m_valid, 0);
    user_aresetn = 1'b1;
    clear_logs();
    for (int k = 0; k < 6; k++) step();
    check("t6_ngrant", g_id.size(), 3);
    if (g_id.size() > 0) check("t6_first", g_id[0], 0);

    total = 0;
    for (int i = 0; i < NR; i++) total += exp_q[i].size();
    check("sb_drained", total, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
